// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: owns the sequential fetch PC, issues word reads to the
// instruction memory and queues {pc, instr} pairs for the core behind a valid/ready port.
module instr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    input  logic               out_ready,
    output logic               mem_en,
    output logic [IMEM_AW-1:0] mem_addr,
    input  logic [31:0]        mem_rdata
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntDepth = CntW'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] instr_q [DEPTH];

    logic full;
    logic empty;
    logic issue;
    logic pop;

    // Low PC bits are always forced to zero on redirect.
    logic unused_redirect_pc_lsb;
    assign unused_redirect_pc_lsb = ^redirect_pc[1:0];

    assign full  = (count_q == CntDepth);
    assign empty = (count_q == '0);

    // rst gates the enable so no read is requested while reset is held.
    assign mem_en   = rst & ~redirect & ~full;
    assign mem_addr = fetch_pc_q[IMEM_AW+1:2];
    assign issue    = mem_en;

    assign out_valid = ~empty;
    assign out_pc    = pc_q[rd_ptr_q];
    assign out_instr = instr_q[rd_ptr_q];
    assign pop       = out_valid & out_ready & ~redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                wr_ptr_d   = wr_ptr_q + PtrOne;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (issue && !pop) begin
                count_d = count_q + CntOne;
            end else if (pop && !issue) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (issue) begin
            pc_q[wr_ptr_q]    <= fetch_pc_q;
            instr_q[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: directed scenarios plus random ready/redirect
// traffic, compared against a queue-based model of the fetch stream.
module tb_instr_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned IMEM_AW  = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               out_valid;
    logic [31:0]        out_instr;
    logic [31:0]        out_pc;
    logic               out_ready;
    logic               mem_en;
    logic [IMEM_AW-1:0] mem_addr;
    logic [31:0]        mem_rdata;

    int errors = 0;
    int checks = 0;

    // Model: PCs of words held in the buffer, oldest first, plus the next fetch PC.
    logic [31:0] exp_q[$];
    logic [31:0] exp_fpc;

    instr_prefetch #(
        .DEPTH   (DEPTH),
        .IMEM_AW (IMEM_AW),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory on the inverted clock; word k holds 0x1000_0000 + k.
    always @(negedge clk) begin
        if (mem_en) mem_rdata <= 32'h1000_0000 + 32'(mem_addr);
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + 32'(pc[IMEM_AW+1:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        bit iss;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        iss = !rd && (exp_q.size() < int'(DEPTH));
        #3;
        check("mem_en", 32'(mem_en), 32'(iss));
        check("mem_addr", 32'(mem_addr), 32'(exp_fpc[IMEM_AW+1:2]));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out_pc", out_pc, exp_q[0]);
            check("out_instr", out_instr, word_of(exp_q[0]));
        end
        @(posedge clk);
        if (rd) begin
            exp_q.delete();
            exp_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
            if (iss) begin
                exp_q.push_back(exp_fpc);
                exp_fpc = exp_fpc + 32'd4;
            end
        end
        #1;
    endtask

    // Assert reset between clock edges and check that outputs drop without a clock.
    task automatic async_reset();
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC[IMEM_AW+1:2]));
        exp_q.delete();
        exp_fpc = RESET_PC;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        mem_rdata   = '0;
        exp_fpc     = RESET_PC;
        #2;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_mem_en", 32'(mem_en), 32'd0);
        check("init_out_pc", out_pc, 32'd0);
        check("init_out_instr", out_instr, 32'd0);
        check("init_mem_addr", 32'(mem_addr), 32'(RESET_PC[IMEM_AW+1:2]));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming from reset with ready held high.
        repeat (12) step(1'b0, 32'd0, 1'b1);

        // Backpressure from a fresh reset, then release.
        async_reset();
        repeat (10) step(1'b0, 32'd0, 1'b0);
        repeat (12) step(1'b0, 32'd0, 1'b1);

        // Build three entries, then redirect with ready high.
        step(1'b1, 32'h0000_0200, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h0000_0042, 1'b1);
        repeat (6) step(1'b0, 32'd0, 1'b1);

        // Back-to-back redirects.
        step(1'b1, 32'h0000_0080, 1'b1);
        step(1'b1, 32'h0000_00C0, 1'b1);
        repeat (6) step(1'b0, 32'd0, 1'b1);

        // Memory address wrap.
        step(1'b1, 32'h0000_03FC, 1'b1);
        repeat (6) step(1'b0, 32'd0, 1'b1);

        // Random traffic, with one asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            logic        rd;
            logic        rdy;
            logic [31:0] rpc;
            rd  = ($urandom_range(15) == 0);
            rdy = ($urandom_range(3) != 0);
            rpc = $urandom();
            if (i == 200) async_reset();
            step(rd, rpc, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch buffer between the core's fetch stage and the instruction memory. It owns the sequential fetch PC and issues word reads to the instruction memory, which is clocked on the inverted system clock. It queues returned words with their PC tags in a small FIFO and hands them to the core over a valid/ready handshake. A redirect from the core (branch, jump, trap) flushes the queue and restarts fetch at a new PC.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- IMEM_AW, 8: instruction-memory word-address width.
- RESET_PC, 32'h0000_0000: first fetch PC after reset.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_instr  out  32  instruction word at the FIFO head.
- out_pc  out  32  PC of out_instr.
- out_ready  in  1  core accepts the head this cycle.
- mem_en  out  1  instruction-memory read enable.
- mem_addr  out  IMEM_AW  word address, equal to fetch_pc[IMEM_AW+1:2].
- mem_rdata  in  32  read data, valid before the rising edge that ends the cycle in which mem_en=1.

## Operation
- State:
  - fetch_pc (32 bits)
  - FIFO of DEPTH entries {pc, instr}
  - rd_ptr and wr_ptr, each log2(DEPTH) bits
  - count, log2(DEPTH)+1 bits
- full = (count==DEPTH). empty = (count==0).
- pop = out_valid & out_ready & ~redirect.
- Issue:
  - mem_en = ~redirect & ~full. This is combinational from state and redirect only; there is no path from out_ready.
  - On an issue edge, write {fetch_pc, mem_rdata} at wr_ptr, increment wr_ptr, and set fetch_pc to fetch_pc+4.
- Pop: increment rd_ptr on a pop edge.
- count update on each edge: +1 on issue only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous issue and pop on a full FIFO cannot occur, because mem_en=0 when full.
- out_valid = ~empty. out_instr and out_pc are driven from the entry at rd_ptr and are combinational from FIFO state.
- Redirect has priority over every other event in its cycle:
  - mem_en=0 in that cycle and no pop occurs.
  - At the edge: count, rd_ptr and wr_ptr go to 0, and fetch_pc goes to {redirect_pc[31:2], 2'b00}.
  - The head word presented in the redirect cycle is discarded even if out_ready=1.
- Back-to-back redirects: each one is applied in turn; the last one wins.
- Wrap-around:
  - fetch_pc+4 wraps modulo 2^32.
  - mem_addr wraps modulo 2^IMEM_AW with no error indication.
  - FIFO pointers wrap modulo DEPTH.
- No instruction decode, no branch prediction, no compressed-instruction support.

## Timing
- During reset (rst=0), asynchronously:
  - fetch_pc=RESET_PC; count, rd_ptr and wr_ptr = 0.
  - FIFO contents = 0; out_valid=0, out_instr=0, out_pc=0.
  - mem_en=0 is forced while rst=0, regardless of the combinational equation.
  - mem_addr = RESET_PC[IMEM_AW+1:2].
- First cycle after rst rises: mem_en=1 with mem_addr=RESET_PC word.
- Issue-to-visible latency is 1 cycle. A word fetched in cycle N appears on out_* in cycle N+1.
- Redirect asserted in cycle N:
  - out_valid=0 in N+1, with mem_en=1 at the new address.
  - The new PC's instruction is on out_* in N+2.
- Throughput is one instruction per cycle when out_ready is held high (DEPTH ≥ 2).
- Backpressure: with out_ready=0, the FIFO fills to DEPTH in DEPTH cycles, then mem_en=0.
  - Fetch resumes the cycle after the first pop edge.
  - No word is lost or duplicated.
- If rst is asserted mid-stream, all state clears immediately, independent of clk. Any in-progress handshake is abandoned.

## Test plan
- Reset release, memory word k = 32'h1000_0000+k, out_ready=1:
  - out_valid rises 1 cycle after the first mem_en.
  - out_pc sequence is 0,4,8,… with matching words.
  - No gaps.
- Backpressure, out_ready=0 for 10 cycles, then 1:
  - count stops at 4 and mem_en=0 while full.
  - After release, the stream continues in order from out_pc=0 with no loss or duplication.
- Redirect to 32'h0000_0042 while the FIFO holds 3 entries and out_ready=1:
  - The head is not consumed in the redirect cycle.
  - out_valid=0 for 1 cycle.
  - The next out_pc=32'h0000_0040 with word 16.
- Two redirects on consecutive cycles (to 0x80, then 0xC0): only 0xC0 appears; nothing from 0x80 is ever output.
- Address wrap with IMEM_AW=8:
  - A redirect to 0x3FC yields mem_addr=255, then 0.
  - out_pc continues 0x3FC, 0x400 with words 255, 0.
- rst pulled low mid-stream (asynchronous, between edges):
  - out_valid and mem_en drop immediately.
  - After release, fetch restarts at RESET_PC.
